// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid buffer between the ALU and writeback that commits N/Z/C/V to the CCR in order on drain.
// Optional sticky-overflow flag is enabled with ALU_STICKY_OVF_EN.
module alu_result_stage #(
  parameter int LEN = 4,
  parameter int RDW = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_result,
  input  logic           in_n,
  input  logic           in_c,
  input  logic           in_z,
  input  logic           in_v,
  input  logic           in_setflags,
  input  logic [RDW-1:0] in_rd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_result,
  output logic [RDW-1:0] out_rd,
  output logic [3:0]     ccr
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic           ovf_clr,
  output logic           ovf_sticky
`endif
);
  localparam int W = LEN + 5 + RDW;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t         r_state;
  logic [W-1:0]   r_head, r_skid;
  logic           r_in_ready, r_out_valid;
  logic [3:0]     r_ccr;
  logic [W-1:0]   w_in;
  logic           w_accept, w_drain;
  // entry layout: {result, n, c, z, v, setflags, rd}
  assign w_in       = {in_result, in_n, in_c, in_z, in_v, in_setflags, in_rd};
  assign in_ready   = reset_n & r_in_ready;
  assign out_valid  = r_out_valid;
  assign w_accept   = in_valid & in_ready;
  assign w_drain    = r_out_valid & out_ready;
  assign out_result = r_head[W-1 -: LEN];
  assign out_rd     = r_head[RDW-1:0];
  assign ccr        = r_ccr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ccr       <= 4'b0000;
    end else begin
      if (w_drain && r_head[RDW])
        r_ccr <= {r_head[RDW+4], r_head[RDW+2], r_head[RDW+3], r_head[RDW+1]};
      case (r_state)
        EMPTY: if (w_accept) begin
          r_state     <= ONE;
          r_head      <= w_in;
          r_out_valid <= 1'b1;
        end
        ONE: if (w_accept && !w_drain) begin
          r_state    <= TWO;
          r_skid     <= w_in;
          r_in_ready <= 1'b0;
        end else if (w_accept) begin
          r_head <= w_in;
        end else if (w_drain) begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
        end
        TWO: if (w_drain) begin
          r_state    <= ONE;
          r_head     <= r_skid;
          r_in_ready <= 1'b1;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
`ifdef ALU_STICKY_OVF_EN
  logic r_ovf_sticky;
  assign ovf_sticky = r_ovf_sticky;
  // a setting drain takes priority over a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ovf_sticky <= 1'b0;
    else r_ovf_sticky <= (w_drain && r_head[RDW] && r_head[RDW+1]) ? 1'b1 : ovf_clr ? 1'b0 : r_ovf_sticky;
  end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed stimulus with a queue-based reference model checked every cycle.
module tb_alu_result_stage;
  localparam int LEN = 4;
  localparam int RDW = 3;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 0;
  logic in_n = 0, in_c = 0, in_z = 0, in_v = 0, in_setflags = 0;
  logic [LEN-1:0] in_result = '0;
  logic [RDW-1:0] in_rd = '0;
  logic in_ready, out_valid;
  logic [LEN-1:0] out_result;
  logic [RDW-1:0] out_rd;
  logic [3:0] ccr;
`ifdef ALU_STICKY_OVF_EN
  logic ovf_clr = 0, ovf_sticky;
`endif
  int checks = 0, failures = 0;

  alu_result_stage #(.LEN(LEN), .RDW(RDW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_n(in_n), .in_c(in_c), .in_z(in_z), .in_v(in_v),
    .in_setflags(in_setflags), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .ccr(ccr)
`ifdef ALU_STICKY_OVF_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LEN-1:0] res;
    logic n, c, z, v, sf;
    logic [RDW-1:0] rd;
  } ent_t;
  ent_t q[$];
  ent_t last;
  logic [3:0] m_ccr = 4'b0000;
  logic m_sticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // reference model: a 2-deep FIFO with in-order flag commit
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      last = '{res: '0, n: 0, c: 0, z: 0, v: 0, sf: 0, rd: '0};
      m_ccr = 4'b0000;
      m_sticky = 1'b0;
    end else begin
      bit acc, drn;
      ent_t e;
      acc = in_valid && q.size() < 2;
      drn = q.size() > 0 && out_ready;
`ifdef ALU_STICKY_OVF_EN
      if (ovf_clr) m_sticky = 1'b0;
`endif
      if (drn) begin
        e = q.pop_front();
        last = e;
        if (e.sf) m_ccr = {e.n, e.z, e.c, e.v};
        if (e.sf && e.v) m_sticky = 1'b1;
      end
      if (acc) q.push_back('{res: in_result, n: in_n, c: in_c, z: in_z, v: in_v, sf: in_setflags, rd: in_rd});
    end
  end

  always @(negedge clk) begin
    ent_t h;
    h = q.size() > 0 ? q[0] : last;
    chk("m_out_valid", out_valid, q.size() > 0);
    chk("m_in_ready", in_ready, reset_n && q.size() < 2);
    chk("m_out_result", out_result, h.res);
    chk("m_out_rd", out_rd, h.rd);
    chk("m_ccr", ccr, m_ccr);
`ifdef ALU_STICKY_OVF_EN
    chk("m_sticky", ovf_sticky, m_sticky);
`endif
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [LEN-1:0] r, input logic n, c, z, v, sf, input logic [RDW-1:0] rd);
    in_valid = 1; in_result = r; in_n = n; in_c = c; in_z = z; in_v = v; in_setflags = sf; in_rd = rd;
  endtask

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    #9 reset_n = 1;
    #1;
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_ccr", ccr, 4'b0000);
    chk("rel_in_ready", in_ready, 1);
    // single op
    out_ready = 1;
    op(4'b1111, 1, 0, 0, 0, 1, 3'd5);
    tick;
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 4'b1111);
    chk("t1_rd", out_rd, 5);
    chk("t1_ccr_pre", ccr, 4'b0000);
    in_valid = 0;
    tick;
    chk("t1_ccr", ccr, 4'b1000);
    chk("t1_empty", out_valid, 0);
    // back-pressure
    out_ready = 0;
    op(4'd1, 0, 0, 0, 0, 0, 3'd1); tick;
    op(4'd2, 0, 0, 0, 0, 0, 3'd2); tick;
    op(4'd3, 0, 0, 0, 0, 0, 3'd3); tick;
    chk("t2_full", in_ready, 0);
    chk("t2_headA", out_result, 4'd1);
    tick;
    chk("t2_holdA", out_result, 4'd1);
    out_ready = 1;
    tick;
    chk("t2_headB", out_result, 4'd2);
    tick;
    chk("t2_headC", out_result, 4'd3);
    chk("t2_rdC", out_rd, 3'd3);
    in_valid = 0;
    tick;
    chk("t2_empty", out_valid, 0);
    chk("t2_keep", out_result, 4'd3);
    // streaming
    for (int i = 0; i < 8; i++) begin
      op(LEN'(i), 0, 0, 0, 0, 0, RDW'(i));
      tick;
      chk("t3_result", out_result, i);
      chk("t3_ready", in_ready, 1);
    end
    in_valid = 0;
    tick;
    chk("t3_empty", out_valid, 0);
    // setflags
    op(4'b0001, 0, 0, 0, 0, 0, 3'd1); tick; in_valid = 0; tick;
    chk("t4_nosf", ccr, 4'b1000);
    op(4'b1101, 1, 0, 0, 0, 1, 3'd2); tick; in_valid = 0; tick;
    chk("t4_n", ccr, 4'b1000);
    op(4'b0000, 0, 0, 1, 0, 1, 3'd3); tick; in_valid = 0; tick;
    chk("t4_z", ccr, 4'b0100);
    // reset while TWO
    out_ready = 0;
    op(4'd5, 0, 0, 0, 1, 1, 3'd2); tick;
    op(4'd6, 0, 0, 0, 0, 1, 3'd3); tick;
    in_valid = 0;
    chk("t5_two", in_ready, 0);
    #2 reset_n = 0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_ccr", ccr, 4'b0000);
    chk("t5_rdy", in_ready, 0);
    tick;
    #2 reset_n = 1;
    out_ready = 1;
    tick;
    chk("t5_rel_ready", in_ready, 1);
    chk("t5_rel_valid", out_valid, 0);
    chk("t5_rel_result", out_result, 0);
    tick;
    chk("t5_no_stale", out_valid, 0);
`ifdef ALU_STICKY_OVF_EN
    op(4'd7, 0, 0, 0, 1, 1, 3'd1); tick; in_valid = 0; tick;
    chk("t6_set", ovf_sticky, 1);
    op(4'd1, 0, 0, 0, 0, 1, 3'd1); tick; in_valid = 0; tick;
    chk("t6_keep", ovf_sticky, 1);
    op(4'd7, 0, 0, 0, 1, 1, 3'd1); tick; in_valid = 0; ovf_clr = 1; tick;
    chk("t6_setwins", ovf_sticky, 1);
    tick;
    ovf_clr = 0;
    chk("t6_clr", ovf_sticky, 0);
`endif
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
